// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU op classes and the control bundle.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned IMM_W    = 12;
    localparam int unsigned FUNCT_W  = 10;
    localparam int unsigned ALU_OP_W = 2;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'b10;

    // Control bundle carried across the ID/EX boundary
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/regfile_bp.sv
// Register file with synchronous reset, hard-wired x0 and two combinational read ports.
// Optional write-through bypass when ID_BYPASS_EN is defined.
module regfile_bp #(
    parameter int unsigned XLEN   = 8,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [XLEN-1:0]   rd_data1_c,
    output logic [XLEN-1:0]   rd_data2_c
);

    localparam int unsigned NREG = 2 ** REG_AW;

    logic [XLEN-1:0] regs [NREG];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Write port; x0 is never written so it stays at its reset value of 0
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports; x0 forced to 0, optional same-cycle write-through
    always_comb begin
        rd_data1_c = regs[rd_addr1];
        rd_data2_c = regs[rd_addr2];
`ifdef ID_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr1)) rd_data1_c = wr_data;
        if (wr_live && (wr_addr == rd_addr2)) rd_data2_c = wr_data;
`endif
        if (rd_addr1 == '0) rd_data1_c = '0;
        if (rd_addr2 == '0) rd_data2_c = '0;
    end

endmodule

// File: rtl/id_stage_hz.sv
// Instruction-decode stage: decode, register read, load-use hazard detection
// and the ID/EX pipeline register with valid, stall and flush handling.
// Optional macro ID_BYPASS_EN enables register-file write-through.
module id_stage_hz
    import riscv_pkg::*;
#(
    parameter int unsigned PC_SIZE = 10,
    parameter int unsigned XLEN    = 8,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_SIZE-1:0]  pc_in,
    input  logic [31:0]         instruction,
    input  logic                instr_valid,
    input  logic                stall_in,
    input  logic                flush,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                stall_out,
    output logic                out_valid,
    output logic [PC_SIZE-1:0]  pc_out,
    output logic [REG_AW-1:0]   rs1,
    output logic [REG_AW-1:0]   rs2,
    output logic [REG_AW-1:0]   rd,
    output logic [XLEN-1:0]     read_data1,
    output logic [XLEN-1:0]     read_data2,
    output logic [IMM_W-1:0]    immediate,
    output logic [FUNCT_W-1:0]  funct,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                branch,
    output logic [ALU_OP_W-1:0] alu_op
);

    logic [OPCODE_W-1:0] opcode;
    logic [REG_AW-1:0]   dec_rs1;
    logic [REG_AW-1:0]   dec_rs2;
    logic [REG_AW-1:0]   dec_rd;
    logic [FUNCT_W-1:0]  dec_funct;
    logic [IMM_W-1:0]    dec_imm;
    ctrl_t               dec_ctrl;
    ctrl_t               ctrl_q;
    logic                uses_rs2;
    logic                hazard;
    logic [XLEN-1:0]     rf_data1;
    logic [XLEN-1:0]     rf_data2;

    assign opcode    = instruction[6:0];
    assign dec_rs1   = REG_AW'(instruction[19:15]);
    assign dec_rs2   = REG_AW'(instruction[24:20]);
    assign dec_rd    = REG_AW'(instruction[11:7]);
    assign dec_funct = {instruction[31:25], instruction[14:12]};

    // Control and immediate decode by opcode
    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        uses_rs2 = 1'b0;
        unique case (opcode)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
                uses_rs2           = 1'b1;
            end
            OP_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
                dec_imm            = instruction[31:20];
            end
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
                dec_imm             = instruction[31:20];
            end
            OP_STORE: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
                dec_imm            = {instruction[31:25], instruction[11:7]};
                uses_rs2           = 1'b1;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
                dec_imm         = {instruction[31], instruction[7],
                                   instruction[30:25], instruction[11:8]};
                uses_rs2        = 1'b1;
            end
            default: ;
        endcase
    end

    // Load-use hazard: the load in ID/EX writes a register this instruction reads
    assign hazard = out_valid && ctrl_q.mem_read && (rd != '0) && instr_valid &&
                    ((rd == dec_rs1) || ((rd == dec_rs2) && uses_rs2));

    assign stall_out = hazard || stall_in;

    regfile_bp #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wb_reg_write),
        .wr_addr    (wb_rd),
        .wr_data    (wb_data),
        .rd_addr1   (dec_rs1),
        .rd_addr2   (dec_rs2),
        .rd_data1_c (rf_data1),
        .rd_data2_c (rf_data2)
    );

    // ID/EX register: reset > flush > stall_in > hazard bubble > capture
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            ctrl_q     <= '0;
            pc_out     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            read_data1 <= '0;
            read_data2 <= '0;
            immediate  <= '0;
            funct      <= '0;
        end else if (flush || (!stall_in && hazard)) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (!stall_in) begin
            out_valid  <= instr_valid;
            ctrl_q     <= instr_valid ? dec_ctrl : '0;
            pc_out     <= pc_in;
            rs1        <= dec_rs1;
            rs2        <= dec_rs2;
            rd         <= dec_rd;
            read_data1 <= rf_data1;
            read_data2 <= rf_data2;
            immediate  <= dec_imm;
            funct      <= dec_funct;
        end
    end

    assign reg_write  = ctrl_q.reg_write;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src    = ctrl_q.alu_src;
    assign branch     = ctrl_q.branch;
    assign alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: default-width instance plus a 16-bit/16-register instance.
module tb_id_stage_hz;

    logic        clock = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    // Default instance (PC_SIZE=10, XLEN=8, REG_AW=5)
    logic [9:0]  pc_in;
    logic [31:0] instruction;
    logic        instr_valid, stall_in, flush, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        stall_out, out_valid;
    logic [9:0]  pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  read_data1, read_data2;
    logic [11:0] immediate;
    logic [9:0]  funct;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
    logic [1:0]  alu_op;

    // Wide instance (XLEN=16, REG_AW=4)
    logic [9:0]  w_pc_in;
    logic [31:0] w_instruction;
    logic        w_instr_valid, w_wb_reg_write;
    logic [3:0]  w_wb_rd;
    logic [15:0] w_wb_data;
    logic        w_stall_out, w_out_valid;
    logic [9:0]  w_pc_out;
    logic [3:0]  w_rs1, w_rs2, w_rd;
    logic [15:0] w_read_data1, w_read_data2;
    logic [11:0] w_immediate;
    logic [9:0]  w_funct;
    logic        w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src, w_branch;
    logic [1:0]  w_alu_op;

    always #5 clock = ~clock;

    id_stage_hz u_dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .instruction(instruction),
        .instr_valid(instr_valid), .stall_in(stall_in), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_out(stall_out), .out_valid(out_valid), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .read_data1(read_data1), .read_data2(read_data2),
        .immediate(immediate), .funct(funct), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .branch(branch), .alu_op(alu_op)
    );

    id_stage_hz #(.PC_SIZE(10), .XLEN(16), .REG_AW(4)) u_dut16 (
        .clock(clock), .reset(reset), .pc_in(w_pc_in), .instruction(w_instruction),
        .instr_valid(w_instr_valid), .stall_in(1'b0), .flush(1'b0),
        .wb_reg_write(w_wb_reg_write), .wb_rd(w_wb_rd), .wb_data(w_wb_data),
        .stall_out(w_stall_out), .out_valid(w_out_valid), .pc_out(w_pc_out),
        .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .read_data1(w_read_data1),
        .read_data2(w_read_data2), .immediate(w_immediate), .funct(w_funct),
        .reg_write(w_reg_write), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .mem_to_reg(w_mem_to_reg), .alu_src(w_alu_src), .branch(w_branch), .alu_op(w_alu_op)
    );

    localparam logic [31:0] I_ADDI_X2_X1_5 = 32'h0050_8113;
    localparam logic [31:0] I_LW_X3_X1     = 32'h0000_A183;
    localparam logic [31:0] I_ADD_X4_X3_X2 = 32'h0021_8233;
    localparam logic [31:0] I_ADDI_X4_X0_3 = 32'h0030_0213;
    localparam logic [31:0] I_SW_X2_8_X1   = 32'h0020_A423;
    localparam logic [31:0] I_BEQ_X1_X2_16 = 32'h0020_8863;
    localparam logic [31:0] I_ADDI_X2_X0_1 = 32'h0010_0113;
    localparam logic [31:0] I_ADD_X6_X5_X0 = 32'h0002_8333;
    localparam logic [31:0] I_ADD_X8_X7_X0 = 32'h0003_8433;
    localparam logic [31:0] I_ADD_X8_X0_X0 = 32'h0000_0433;
    localparam logic [31:0] I_UNKNOWN      = 32'h0000_007F;

`ifdef ID_BYPASS_EN
    localparam logic [15:0] X7_SAME_CYCLE = 16'hBEEF;
`else
    localparam logic [15:0] X7_SAME_CYCLE = 16'h1234;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packed controls: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
    function automatic logic [31:0] ctrls();
        return 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op});
    endfunction

    task automatic present(input logic [9:0] pc, input logic [31:0] ins);
        pc_in = pc;
        instruction = ins;
        instr_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        pc_in = '0; instruction = '0; instr_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        w_pc_in = '0; w_instruction = '0; w_instr_valid = 1'b0;
        w_wb_reg_write = 1'b0; w_wb_rd = '0; w_wb_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_ctrls", ctrls(), 32'h0);
        chk("rst_stall_out", 32'(stall_out), 32'h0);
        chk("rst_pc_rd", 32'({pc_out, rd, immediate}), 32'h0);
        reset = 1'b0;

        // Writeback x1 = 0x12, then decode addi x2,x1,5
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 8'h12;
        tick();
        wb_reg_write = 1'b0;
        present(10'h004, I_ADDI_X2_X1_5);
        tick();
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_rd1", 32'(read_data1), 32'h12);
        chk("addi_imm", 32'(immediate), 32'h005);
        chk("addi_ctrls", ctrls(), 32'b1000_1010);
        chk("addi_rd", 32'(rd), 32'h2);
        chk("addi_pc", 32'(pc_out), 32'h004);

        // Load-use: lw x3 then add x4,x3,x2
        present(10'h008, I_LW_X3_X1);
        tick();
        chk("lw_ctrls", ctrls(), 32'b1101_1000);
        present(10'h00C, I_ADD_X4_X3_X2);
        #1;
        chk("lu_stall_out", 32'(stall_out), 32'h1);
        tick();
        chk("lu_bubble_valid", 32'(out_valid), 32'h0);
        chk("lu_bubble_ctrls", ctrls(), 32'h0);
        chk("lu_stall_clear", 32'(stall_out), 32'h0);
        tick();
        chk("lu_add_valid", 32'(out_valid), 32'h1);
        chk("lu_add_rs1", 32'(rs1), 32'h3);
        chk("lu_add_ctrls", ctrls(), 32'b1000_0010);
        chk("lu_add_pc", 32'(pc_out), 32'h00C);

        // I-type whose imm field matches the load rd must not stall
        present(10'h010, I_LW_X3_X1);
        tick();
        present(10'h014, I_ADDI_X4_X0_3);
        #1;
        chk("itype_no_hazard", 32'(stall_out), 32'h0);

        // Flush beats hazard
        present(10'h018, I_LW_X3_X1);
        tick();
        present(10'h01C, I_ADD_X4_X3_X2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ctrls", ctrls(), 32'h0);

        // Store, then hold with stall_in for 3 cycles
        present(10'h020, I_SW_X2_8_X1);
        tick();
        chk("sw_ctrls", ctrls(), 32'b0010_1000);
        chk("sw_imm", 32'(immediate), 32'h008);
        chk("sw_funct", 32'(funct), 32'h002);
        stall_in = 1'b1;
        present(10'h024, I_ADDI_X2_X1_5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stall_out", 32'(stall_out), 32'h1);
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_ctrls", ctrls(), 32'b0010_1000);
            chk("hold_fields", 32'({pc_out, immediate, rs2}), 32'({10'h020, 12'h008, 5'd2}));
        end
        stall_in = 1'b0;

        // Branch decode
        present(10'h028, I_BEQ_X1_X2_16);
        tick();
        chk("beq_ctrls", ctrls(), 32'b0000_0101);
        chk("beq_imm", 32'(immediate), 32'h008);
        chk("beq_rd1", 32'(read_data1), 32'h12);

        // Unknown opcode stays valid with zero controls; invalid input gives a bubble
        present(10'h02C, I_UNKNOWN);
        tick();
        chk("unk_valid", 32'(out_valid), 32'h1);
        chk("unk_ctrls_imm", 32'({ctrls(), immediate}), 32'h0);
        instr_valid = 1'b0;
        instruction = I_ADD_X4_X3_X2;
        tick();
        chk("inv_valid_ctrls", 32'({out_valid, ctrls()}), 32'h0);

        // x0 write ignored even in the same cycle as a read
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 8'hFF;
        present(10'h030, I_ADDI_X2_X0_1);
        tick();
        wb_reg_write = 1'b0;
        chk("x0_same_cycle", 32'(read_data1), 32'h0);
        tick();
        chk("x0_after", 32'(read_data1), 32'h0);

        // Reset mid-stream with a load in ID/EX clears x5
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 8'h55;
        instr_valid = 1'b0;
        tick();
        wb_reg_write = 1'b0;
        present(10'h034, I_LW_X3_X1);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_hold_stall_out", 32'(stall_out), 32'h0);
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ctrls", ctrls(), 32'h0);
        chk("mid_rst_fields", 32'({pc_out, immediate, rd}), 32'h0);
        chk("mid_rst_data", 32'({read_data1, read_data2, funct}), 32'h0);
        present(10'h038, I_ADD_X6_X5_X0);
        tick();
        chk("x5_cleared", 32'(read_data1), 32'h0);

        // Wide instance: same-cycle write/read of x7, and x0
        w_wb_reg_write = 1'b1; w_wb_rd = 4'd7; w_wb_data = 16'h1234;
        tick();
        w_wb_data = 16'hBEEF;
        w_instruction = I_ADD_X8_X7_X0; w_instr_valid = 1'b1; w_pc_in = 10'h040;
        tick();
        w_wb_reg_write = 1'b0;
        chk("w_x7_same_cycle", 32'(w_read_data1), 32'(X7_SAME_CYCLE));
        chk("w_rd", 32'(w_rd), 32'h8);
        tick();
        chk("w_x7_after", 32'(w_read_data1), 32'hBEEF);
        w_wb_reg_write = 1'b1; w_wb_rd = 4'd0; w_wb_data = 16'hFFFF;
        w_instruction = I_ADD_X8_X0_X0;
        tick();
        w_wb_reg_write = 1'b0;
        chk("w_x0_same_cycle", 32'(w_read_data1), 32'h0);
        tick();
        chk("w_x0_after", 32'(w_read_data1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
